// File: rtl/calc_core.sv
// Keypad calculator arithmetic core: operand capture, radix-2 Booth multiplier and
// double-dabble binary-to-BCD display conversion. Define CALC_CORE_SIGNED_EN for two's-complement operation.
module calc_core #(
  parameter int W      = 8,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [W-1:0]        a_in,
  input  logic                b_valid,
  input  logic [W-1:0]        b_in,
  input  logic                clear,
  output logic                busy,
  output logic                done,
  output logic [2*W-1:0]      product,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic                bcd_valid,
  output logic [1:0]          sel
);

`ifdef CALC_CORE_SIGNED_EN
  localparam int IT = W;
`else
  localparam int IT = W + 1;
`endif
  localparam int PW = IT + 1;         // partial-product width, one guard bit for -(most negative)
  localparam int AW = PW + IT + 1;    // {partial, multiplier, booth lookbehind bit}
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + 2 * W;     // double-dabble scratch: {digits, binary}
  localparam int CW = $clog2(2 * W);
  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_P = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, CONV = 2'd2} state_t;

  state_t         state, state_n;
  logic [W-1:0]   a_reg, b_reg;
  logic [AW-1:0]  acc, acc_step;
  logic [PW-1:0]  m_ext, p_cur, p_sum;
  logic [IT-1:0]  q_ext;
  logic [SW-1:0]  sreg, sreg_step;
  logic [CW-1:0]  cnt;
  logic           load;
  logic [1:0]     conv_sel;
  logic           conv_neg;
  logic [2*W-1:0] product_n;
  logic [2*W:0]   prod_mag, a_mag;
  logic           start_a, start_mul, mul_last, conv_last;

  // Returns {negative, magnitude} of a 2W-bit value.
  function automatic logic [2*W:0] to_mag(input logic [2*W-1:0] v);
`ifdef CALC_CORE_SIGNED_EN
    if (v[2*W-1]) return {1'b1, -v};
    return {1'b0, v};
`else
    return {1'b0, v};
`endif
  endfunction

  function automatic logic [2*W-1:0] ext_a(input logic [W-1:0] v);
`ifdef CALC_CORE_SIGNED_EN
    return {{W{v[W-1]}}, v};
`else
    return {{W{1'b0}}, v};
`endif
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[2*W+4*i +: 4] >= 4'd5) t[2*W+4*i +: 4] = t[2*W+4*i +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

`ifdef CALC_CORE_SIGNED_EN
  assign m_ext = {a_reg[W-1], a_reg};
  assign q_ext = b_reg;
`else
  assign m_ext = {2'b00, a_reg};
  assign q_ext = {1'b0, b_reg};
`endif

  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    p_cur     = acc[AW-1:IT+1];
    p_sum     = p_cur;
    case (acc[1:0])
      2'b01:   p_sum = p_cur + m_ext;
      2'b10:   p_sum = p_cur - m_ext;
      default: p_sum = p_cur;
    endcase
    acc_step  = {p_sum[PW-1], p_sum, acc[IT:1]};
    product_n = acc_step[2*W:1];
    prod_mag  = to_mag(product_n);
    a_mag     = to_mag(ext_a(a_reg));
    sreg_step = dabble(sreg);
  end

  always_comb begin
    state_n   = state;
    start_mul = (state == IDLE) && b_valid;
    start_a   = (state == IDLE) && a_valid && !b_valid;
    mul_last  = (state == MUL)  && !load && (cnt == CW'(IT - 1));
    conv_last = (state == CONV) && !load && (cnt == CW'(2 * W - 1));
    case (state)
      IDLE:    if (start_mul) state_n = MUL;
               else if (start_a) state_n = CONV;
      MUL:     if (mul_last) state_n = CONV;
      CONV:    if (conv_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) state <= IDLE;
    else              state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      sreg      <= '0;
      cnt       <= '0;
      load      <= 1'b0;
      conv_sel  <= 2'b00;
      conv_neg  <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      bcd_valid <= 1'b0;
      sel       <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mul) begin
            if (a_valid) a_reg <= a_in;
            b_reg     <= b_in;
            load      <= 1'b1;
            bcd_valid <= 1'b0;
          end else if (start_a) begin
            a_reg     <= a_in;
            load      <= 1'b1;
            conv_sel  <= SEL_A;
            bcd_valid <= 1'b0;
          end
        end
        MUL: begin
          if (load) begin
            acc  <= {{PW{1'b0}}, q_ext, 1'b0};
            cnt  <= '0;
            load <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (mul_last) begin
              // Product goes straight into the converter; no load cycle on this path.
              product  <= product_n;
              done     <= 1'b1;
              conv_sel <= SEL_P;
              conv_neg <= prod_mag[2*W];
              sreg     <= {{BW{1'b0}}, prod_mag[2*W-1:0]};
              cnt      <= '0;
            end
          end
        end
        CONV: begin
          if (load) begin
            conv_neg <= a_mag[2*W];
            sreg     <= {{BW{1'b0}}, a_mag[2*W-1:0]};
            cnt      <= '0;
            load     <= 1'b0;
          end else begin
            sreg <= sreg_step;
            cnt  <= cnt + 1'b1;
            if (conv_last) begin
              bcd       <= sreg_step[SW-1:2*W];
              sel       <= conv_sel;
              neg       <= conv_neg;
              bcd_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core (W=8, DIGITS=5); follows CALC_CORE_SIGNED_EN when defined.
module tb_calc_core;
  localparam int W = 8;
  localparam int DIGITS = 5;
`ifdef CALC_CORE_SIGNED_EN
  localparam int ITER = W;
`else
  localparam int ITER = W + 1;
`endif

  typedef struct packed {
    logic [19:0] bcd;
    logic [1:0]  sel;
    logic        neg;
  } disp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, clear = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;
  logic        busy, done, neg, bcd_valid;
  logic [15:0] product;
  logic [19:0] bcd;
  logic [1:0]  sel;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic bv_prev = 1'b0;
  logic [7:0] model_a = '0;
  logic [15:0] prod_q[$];
  disp_t disp_q[$];

  calc_core #(.W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_in(a_in), .b_valid(b_valid),
    .b_in(b_in), .clear(clear), .busy(busy), .done(done), .product(product),
    .bcd(bcd), .neg(neg), .bcd_valid(bcd_valid), .sel(sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int to_int(input logic [7:0] x);
`ifdef CALC_CORE_SIGNED_EN
    return x[7] ? int'(x) - 256 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic disp_t mk_disp(input int v, input logic [1:0] s);
    disp_t d;
    d.neg = (v < 0);
    d.bcd = to_bcd(v < 0 ? -v : v);
    d.sel = s;
    return d;
  endfunction

  // Output monitor: pops expectations when the DUT announces a result.
  always @(negedge clk) begin
    disp_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (prod_q.size() == 0) check("unexpected_done", done, 1'b0);
      else check("product", product, prod_q.pop_front());
    end
    if (bcd_valid && !bv_prev) begin
      if (disp_q.size() == 0) check("unexpected_bcd_valid", bcd_valid, 1'b0);
      else begin
        e = disp_q.pop_front();
        check("bcd", bcd, e.bcd);
        check("sel", sel, e.sel);
        check("neg", neg, e.neg);
      end
    end
    bv_prev = bcd_valid;
  end

  task automatic run_op(input logic do_a, input logic do_b, input logic [7:0] a,
                        input logic [7:0] b, input logic inject);
    int n, cap, exp_lat, d0, p;
    d0 = done_cnt;
    if (do_a) model_a = a;
    if (do_b) begin
      p = to_int(model_a) * to_int(b);
      prod_q.push_back(16'(p));
      disp_q.push_back(mk_disp(p, 2'b11));
      exp_lat = ITER + 1 + 2 * W;
    end else begin
      disp_q.push_back(mk_disp(to_int(a), 2'b01));
      exp_lat = 2 * W + 1;
    end
    @(negedge clk);
    a_valid = do_a; b_valid = do_b; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    cap = cyc;
    a_valid = 1'b0; b_valid = 1'b0;
    check("busy_rise", busy, 1'b1);
    check("bcd_valid_clear", bcd_valid, 1'b0);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (inject && n == 3) begin b_valid = 1'b1; b_in = 8'd1; end
      else b_valid = 1'b0;
      if (bcd_valid && !busy) break;
    end
    b_valid = 1'b0;
    check("latency", n, exp_lat);
    if (do_b) check("done_latency", done_cyc - cap, ITER + 1);
    check("done_count", done_cnt - d0, int'(do_b));
  endtask

  task automatic abort_mul(input logic [7:0] b, input logic use_clear);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    b_valid = 1'b1; b_in = b;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (use_clear) clear = 1'b1; else rst = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; rst = 1'b0;
    model_a = '0;
    check("abort_product", product, 16'd0);
    check("abort_outputs", {busy, done, bcd_valid, neg, sel, bcd}, 26'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle", busy, 1'b0);
    check("abort_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_outputs", {busy, done, bcd_valid, neg, sel, bcd}, 26'd0);
    check("rst_product", product, 16'd0);

    run_op(1'b1, 1'b0, 8'd12, 8'd0, 1'b0);
    run_op(1'b0, 1'b1, 8'd0, 8'd34, 1'b0);
    run_op(1'b1, 1'b1, 8'd255, 8'd255, 1'b1);
    run_op(1'b1, 1'b1, 8'hFD, 8'd5, 1'b0);
    run_op(1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
    run_op(1'b1, 1'b1, 8'd7, 8'd6, 1'b0);
    run_op(1'b1, 1'b0, 8'h80, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    abort_mul(8'd9, 1'b0);
    run_op(1'b1, 1'b1, 8'd11, 8'd13, 1'b0);
    abort_mul(8'd9, 1'b1);
    run_op(1'b0, 1'b1, 8'd0, 8'd9, 1'b0);
    run_op(1'b1, 1'b0, 8'd5, 8'd0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("prod_queue_empty", prod_q.size(), 0);
    check("disp_queue_empty", disp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
